// File: rtl/fifo_stream_out.sv
// Burst reader: pops len_i words from a FIFO with one-cycle read latency and
// streams them out through a 2-entry valid/ready skid buffer.
module fifo_stream_out #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              inc_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_inflight;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;

    logic              w_inc;
    logic              w_load;
    logic              w_done;
    logic              w_wr;
    logic              w_xfer;
    logic [2:0]        w_pending;
    logic              w_credit;

    // Stream handshake: a word moves when m_valid_o and m_ready_i are both high
    // in the same cycle; m_data_o is held while valid is high and ready is low.
    assign w_wr      = r_inflight;
    assign w_xfer    = (r_count != 2'd0) && m_ready_i;
    // Credit counts the slot freed by this cycle's transfer so a held-high
    // ready sustains one pop per cycle without ever overfilling the buffer.
    assign w_pending = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_xfer};
    assign w_credit  = (w_pending < 3'd2);

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i && (len_i != '0)) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_inc = !fifo_empty_i && (r_remaining != '0) && w_credit;
                if (w_inc && (r_remaining == LEN_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_inflight && (r_count == 2'd0)) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_inc;
            if (w_load) begin
                r_remaining <= len_i;
            end else if (w_inc) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    // r_buf0 is always the oldest word; a simultaneous write and transfer
    // shifts r_buf1 forward before the new word lands behind it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= 2'd0;
            r_buf0  <= '0;
            r_buf1  <= '0;
        end else begin
            case ({w_wr, w_xfer})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf0 <= rdata_i;
                    end else begin
                        r_buf1 <= rdata_i;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf0  <= r_buf1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf0 <= rdata_i;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign inc_o     = w_inc;
    assign m_data_o  = r_buf0;
    assign m_valid_o = (r_count != 2'd0);
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = w_done;
    assign state_o   = r_state;

endmodule
